poly_horner_seq: RTL and testbench
==================================

// Module: poly_horner_seq
// PURPOSE
//  Sequential unsigned polynomial evaluator using Horner's rule:
//    y = c[DEG]*x^DEG + ... + c[1]*x + c[0]
//  It is the parametrised successor to the fixed x^3 sequential cube unit.
//  Input width, coefficient width, degree and result width are all parameters.
//  Uses one multiply-accumulate datapath, one Horner step per clock.
//  Uses a start/busy/finish handshake and sits beside the other arithmetic
//  units in the polynomial datapath.
// PARAMETERS
//  X_W    2    width of x_in (unsigned)
//  C_W    4    width of each coefficient (unsigned)
//  DEG    3    polynomial degree; must be >= 1
//  OUT_W  12   width of the accumulator and of result_out
// PORTS
//  clk         in   1                clock; all logic is on the rising edge
//  rst_n       in   1                synchronous reset, active-low
//  start       in   1                request evaluation; sampled only in IDLE
//  x_in        in   X_W              operand x; latched when start is accepted
//  coef_in     in   (DEG+1)*C_W      packed coefficients, c[i] = coef_in[i*C_W +: C_W]
//  busy        out  1                high while in CALC
//  finish      out  1                one-cycle pulse: result_out is valid (new)
//  result_out  out  OUT_W            result; holds until the next completion
// BEHAVIOUR
//  Reset (rst_n==0 at a posedge):
//   - state=IDLE, acc=0, idx=0, busy=0, finish=0, result_out=0.
//   - Reset overrides any operation in progress; the result is discarded
//     and finish does not pulse.
//  States: IDLE, CALC.
//  IDLE:
//   - On start==1: latch x_in and coef_in.
//   - acc <= zero-extended c[DEG]; idx <= DEG-1; go to CALC.
//   - busy is high from the next cycle.
//  CALC, each cycle:
//   - acc <= (acc * x + c[idx]) mod 2^OUT_W; idx <= idx-1.
//   - While idx != 0: stay in CALC.
//   - When idx == 0: result_out <= the same value, finish <= 1, go to IDLE.
//  Latency:
//   - start accepted at edge k -> finish=1 for the cycle after edge k+DEG.
//   - busy is high for exactly DEG cycles.
//  finish:
//   - High for exactly one cycle, and only after a completed evaluation.
//   - Otherwise 0.
//  Handshake rules:
//   - start while busy is ignored; the latched operands are not disturbed.
//   - start high in the finish cycle is accepted, because state is already
//     IDLE. This gives back-to-back throughput of one result per DEG+1 cycles.
//   - start held high continuously re-triggers on every IDLE cycle.
//  Arithmetic:
//   - Unsigned. Product and sum are computed at OUT_W bits.
//   - Overflow wraps modulo 2^OUT_W; there is no saturation and no flag.
//   - x and coefficients are zero-extended to OUT_W.
//  x_in and coef_in changes after acceptance have no effect on the
//  evaluation in flight.
// TESTING (defaults unless stated; finish expected DEG+1 cycles after start)
//  1. x=2, c3..c0=1,0,0,0
//     -> result_out=8, finish one cycle (matches the old x^3 unit).
//     x=3 same coefs -> 27.
//  2. x=3, all coefs=15
//     -> result_out=600 (0x258); busy high exactly 3 cycles.
//  3. OUT_W=8, x=3, all coefs=15 -> result_out=88 (600 mod 256, wraps).
//  4. Start x=3, c=1,2,3,4; change x_in to 0 and pulse start during busy
//     -> result_out=58, single finish pulse.
//  5. Back-to-back: start on the finish cycle of test 2 with x=1, coefs 1,1,1,1
//     -> result 600, then 4 after DEG+1 more cycles.
//  6. Assert rst_n=0 mid-CALC
//     -> busy=0, finish=0, result_out=0 next cycle; no stale finish afterwards.
//     x=0, c0=7 -> result_out=7.

Source files
------------

// File: rtl/poly_horner_seq.sv
`default_nettype none
// =============================================================================
// Module   : poly_horner_seq
// Brief    : Sequential unsigned polynomial evaluator, one Horner step per clock
// Revision : 1.0 - initial release
// =============================================================================
module poly_horner_seq #(
    parameter int X_W   = 2,
    parameter int C_W   = 4,
    parameter int DEG   = 3,
    parameter int OUT_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [X_W-1:0]           x_in,
    input  logic [(DEG+1)*C_W-1:0]   coef_in,
    output logic                     busy,
    output logic                     finish,
    output logic [OUT_W-1:0]         result_out
);

    localparam int IDX_W = (DEG > 1) ? $clog2(DEG + 1) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t                   state_q,  state_d;
    logic [OUT_W-1:0]         acc_q,    acc_d;
    logic [IDX_W-1:0]         idx_q,    idx_d;
    logic [X_W-1:0]           x_q,      x_d;
    logic [(DEG+1)*C_W-1:0]   coef_q,   coef_d;
    logic [OUT_W-1:0]         result_q, result_d;
    logic                     finish_q, finish_d;

    logic [C_W-1:0]           coef_arr [DEG+1];
    logic [OUT_W-1:0]         mac;

    generate
        for (genvar gi = 0; gi <= DEG; gi++) begin : g_coef
            assign coef_arr[gi] = coef_q[gi*C_W +: C_W];
        end
    endgenerate

    // Product and sum are both truncated to OUT_W, giving modulo-2^OUT_W wrap.
    assign mac = OUT_W'(acc_q * OUT_W'(x_q)) + OUT_W'(coef_arr[idx_q]);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        x_d      = x_q;
        coef_d   = coef_q;
        result_d = result_q;
        finish_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    coef_d  = coef_in;
                    acc_d   = OUT_W'(coef_in[DEG*C_W +: C_W]);
                    idx_d   = IDX_W'(DEG - 1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = mac;
                idx_d = idx_q - IDX_W'(1);
                if (idx_q == '0) begin
                    result_d = mac;
                    finish_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            x_q      <= '0;
            coef_q   <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            x_q      <= x_d;
            coef_q   <= coef_d;
            result_q <= result_d;
            finish_q <= finish_d;
        end
    end

    assign busy       = (state_q == S_CALC);
    assign finish     = finish_q;
    assign result_out = result_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_horner_seq.sv
`default_nettype none
// Directed bench for poly_horner_seq: default instance plus an OUT_W=8 instance
// sharing the same stimulus to exercise wrap-around.
module tb_poly_horner_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  x_in;
    logic [15:0] coef_in;
    logic        busy,   busy8;
    logic        finish, finish8;
    logic [11:0] result;
    logic [7:0]  result8;

    int n_checks = 0;
    int n_errors = 0;

    poly_horner_seq #(.X_W(2), .C_W(4), .DEG(3), .OUT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .coef_in(coef_in),
        .busy(busy), .finish(finish), .result_out(result)
    );

    poly_horner_seq #(.X_W(2), .C_W(4), .DEG(3), .OUT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .coef_in(coef_in),
        .busy(busy8), .finish(finish8), .result_out(result8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present operands with start for one cycle; returns on the next negedge.
    task automatic issue(input logic [1:0] x, input logic [15:0] c);
        x_in    = x;
        coef_in = c;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Waits (bounded) for finish; lat counts negedges since start was raised.
    task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
        lat      = lat0;
        busy_cnt = 0;
        while (!finish && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Counts finish pulses over n cycles.
    task automatic count_finish(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (finish) cnt++;
        end
    endtask

    int lat, bc, fc;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        x_in    = '0;
        coef_in = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy",   busy,   0);
        check_eq("reset_finish", finish, 0);
        check_eq("reset_result", result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // x^3 compatibility
        issue(2'd2, {4'd1, 4'd0, 4'd0, 4'd0});
        wait_done(1, lat, bc);
        check_eq("t1_result_x2", result, 8);
        check_eq("t1_latency",   lat,    4);
        @(negedge clk);
        check_eq("t1_single_pulse", finish, 0);
        issue(2'd3, {4'd1, 4'd0, 4'd0, 4'd0});
        wait_done(1, lat, bc);
        check_eq("t1_result_x3", result, 27);
        @(negedge clk);

        // All-ones coefficients, then back-to-back start in the finish cycle
        issue(2'd3, {4'd15, 4'd15, 4'd15, 4'd15});
        wait_done(1, lat, bc);
        check_eq("t2_result",    result,  600);
        check_eq("t2_busy_cnt",  bc,      3);
        check_eq("t2_latency",   lat,     4);
        check_eq("t3_wrap8",     result8, 88);
        issue(2'd1, {4'd1, 4'd1, 4'd1, 4'd1});
        wait_done(1, lat, bc);
        check_eq("t5_b2b_result",  result,  4);
        check_eq("t5_b2b_latency", lat,     4);
        check_eq("t5_b2b_result8", result8, 4);
        @(negedge clk);

        // Operand changes and start during busy are ignored
        issue(2'd3, {4'd1, 4'd2, 4'd3, 4'd4});
        x_in    = 2'd0;
        coef_in = '0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(2, lat, bc);
        check_eq("t4_result",  result, 58);
        check_eq("t4_latency", lat,    4);
        count_finish(6, fc);
        check_eq("t4_no_extra_finish", fc, 0);

        // Reset mid-calculation
        issue(2'd3, {4'd15, 4'd15, 4'd15, 4'd15});
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_busy",   busy,   0);
        check_eq("t6_rst_finish", finish, 0);
        check_eq("t6_rst_result", result, 0);
        rst_n = 1'b1;
        count_finish(6, fc);
        check_eq("t6_no_stale_finish", fc, 0);
        issue(2'd0, {4'd0, 4'd0, 4'd0, 4'd7});
        wait_done(1, lat, bc);
        check_eq("t6_result_c0", result, 7);
        check_eq("t6_latency",   lat,    4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
